// File: rtl/vram_port_if.sv
// Bus bundle between the two VRAM masters, the arbiter and the block RAM.
// The slave view is the arbiter; the master view is everything around it
// (scan-out reader, game-logic port and the RAM instance).
interface vram_port_if #(
   parameter int AW = 16,
   parameter int DW = 12
);
   // M0: scan-out reader (read only)
   logic          m0_req;
   logic [AW-1:0] m0_addr;
   logic          m0_gnt;
   logic          m0_rvalid;
   logic [DW-1:0] m0_rdata;

   // M1: game-logic read/write port
   logic          m1_req;
   logic          m1_we;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic          m1_gnt;
   logic          m1_rvalid;
   logic [DW-1:0] m1_rdata;

   // Single RAM port
   logic          ram_wea;
   logic [AW-1:0] ram_addra;
   logic [DW-1:0] ram_dina;
   logic [DW-1:0] ram_douta;

   // Forced-grant indicator
   logic          starved;

   modport slave (
      input  m0_req, m0_addr,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output ram_wea, ram_addra, ram_dina,
      input  ram_douta,
      output starved
   );

   modport master (
      output m0_req, m0_addr,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  ram_wea, ram_addra, ram_dina,
      output ram_douta,
      input  starved
   );
endinterface

// File: rtl/vram_port_arbiter.sv
// VRAM port arbiter: shares one single-port pixel RAM between the VGA
// scan-out reader (M0, priority) and the game-logic port (M1). M1 gets a
// forced grant after waiting MAX_STARVE cycles. Read data is routed back to
// its owner by a tag pipe that matches the RAM read latency.
module vram_port_arbiter #(
   parameter int AW         = 16,
   parameter int DW         = 12,
   parameter int RAM_LAT    = 1,
   parameter int MAX_STARVE = 8
) (
   input  logic       clka,
   input  logic       rst,
   vram_port_if.slave bus
);

   localparam logic [7:0] STARVE_LIM = 8'(MAX_STARVE);
   localparam int         LAST       = RAM_LAT - 1;

   logic [7:0]         starve_cnt_q, starve_cnt_d;
   logic [RAM_LAT-1:0] tag_vld_q, tag_vld_d;
   logic [RAM_LAT-1:0] tag_own_q, tag_own_d;

   logic               m0_gnt;
   logic               m1_gnt;
   logic               force_m1;

   logic [AW-1:0]      addr_mux;
   logic [DW-1:0]      dina_mux;
   logic               wea_mux;

   // Grant selection: starvation guard wins, then M0, then M1; nothing under reset.
   always_comb begin
      m0_gnt   = 1'b0;
      m1_gnt   = 1'b0;
      force_m1 = 1'b0;
      if (!rst) begin
         if (bus.m1_req && (starve_cnt_q == STARVE_LIM)) begin
            m1_gnt   = 1'b1;
            force_m1 = 1'b1;
         end else if (bus.m0_req) begin
            m0_gnt = 1'b1;
         end else if (bus.m1_req) begin
            m1_gnt = 1'b1;
         end
      end
   end

   // Wait counter for M1: counts ungranted request cycles, saturates at the limit.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (m1_gnt || !bus.m1_req) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q < STARVE_LIM) begin
         starve_cnt_d = starve_cnt_q + 8'd1;
      end
   end

   // Tag pipe: stage 0 records this cycle's access, older entries shift toward the output.
   always_comb begin
      tag_vld_d    = '0;
      tag_own_d    = '0;
      // A write occupies a slot but carries no return data.
      tag_vld_d[0] = m0_gnt | (m1_gnt & ~bus.m1_we);
      tag_own_d[0] = m1_gnt;
      for (int i = 1; i < RAM_LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_own_d[i] = tag_own_q[i-1];
      end
   end

   // RAM port mux: the granted master drives the port, idle parks it at zero.
   always_comb begin
      addr_mux = '0;
      dina_mux = '0;
      wea_mux  = 1'b0;
      if (m0_gnt) begin
         addr_mux = bus.m0_addr;
      end else if (m1_gnt) begin
         addr_mux = bus.m1_addr;
         dina_mux = bus.m1_wdata;
         wea_mux  = bus.m1_we;
      end
   end

   // State registers; reset drops every in-flight read and clears the wait count.
   always_ff @(posedge clka) begin
      if (rst) begin
         starve_cnt_q <= '0;
         tag_vld_q    <= '0;
         tag_own_q    <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         tag_vld_q    <= tag_vld_d;
         tag_own_q    <= tag_own_d;
      end
   end

   assign bus.m0_gnt    = m0_gnt;
   assign bus.m1_gnt    = m1_gnt;
   assign bus.starved   = force_m1;

   assign bus.ram_wea   = wea_mux;
   assign bus.ram_addra = addr_mux;
   assign bus.ram_dina  = dina_mux;

   // Return data is gated off while reset is high so nothing leaks out mid-reset.
   assign bus.m0_rvalid = ~rst & tag_vld_q[LAST] & ~tag_own_q[LAST];
   assign bus.m1_rvalid = ~rst & tag_vld_q[LAST] &  tag_own_q[LAST];
   assign bus.m0_rdata  = bus.ram_douta;
   assign bus.m1_rdata  = bus.ram_douta;

endmodule
